servant_mem_sched: RTL and testbench

//  Registered round-robin scheduler sharing the single-port servant_ram between three Wishbone masters.

---
 rtl/servant_mem_sched.sv | 178 +++++++++++++++++
 tb/tb_servant_mem_sched.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servant_mem_sched.sv
// rtl/servant_mem_sched.sv - registered round-robin arbiter sharing servant_ram between ibus, dbus and ext
//
// Purpose: grants the single-port RAM to one of three Wishbone masters at a
// time, holds the grant until the memory acks (or the master aborts, or the
// watchdog fires), then rotates priority to the master after the last owner.
//
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_ibus_*  / o_ibus_*           CPU instruction bus (read only)
//   i_dbus_*  / o_dbus_*           CPU data bus
//   i_ext_*   / o_ext_*            external loader/debug port
//   o_mem_*   / i_mem_*            towards servant_ram
//   o_grant                        current owner 0 ibus, 1 dbus, 2 ext (valid while o_busy)
//   o_busy                         transfer in progress
//   o_timeout                      sticky flag, a watchdog termination has happened
module servant_mem_sched #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [AW-1:0] i_ibus_adr,
  input  logic          i_ibus_cyc,
  output logic [31:0]   o_ibus_rdt,
  output logic          o_ibus_ack,
  input  logic [AW-1:0] i_dbus_adr,
  input  logic [31:0]   i_dbus_dat,
  input  logic [3:0]    i_dbus_sel,
  input  logic          i_dbus_we,
  input  logic          i_dbus_cyc,
  output logic [31:0]   o_dbus_rdt,
  output logic          o_dbus_ack,
  input  logic [AW-1:0] i_ext_adr,
  input  logic [31:0]   i_ext_dat,
  input  logic [3:0]    i_ext_sel,
  input  logic          i_ext_we,
  input  logic          i_ext_cyc,
  output logic [31:0]   o_ext_rdt,
  output logic          o_ext_ack,
  output logic [AW-1:0] o_mem_adr,
  output logic [31:0]   o_mem_dat,
  output logic [3:0]    o_mem_sel,
  output logic          o_mem_we,
  output logic          o_mem_cyc,
  input  logic [31:0]   i_mem_rdt,
  input  logic          i_mem_ack,
  output logic [1:0]    o_grant,
  output logic          o_busy,
  output logic          o_timeout
);

  // A zero TIMEOUT still needs a legal one-bit counter.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [1:0]    grant, grant_nxt;
  logic [1:0]    ptr, ptr_nxt;
  logic [CW-1:0] wdog, wdog_nxt;
  logic          timeout_q, timeout_nxt;

  logic [3:0]    cyc_vec;
  logic          gcyc;
  logic          wd_fire;
  logic          ack_fwd;
  logic [1:0]    win;
  logic          win_ok;
  logic [1:0]    cand;

  function automatic logic [1:0] inc3(input logic [1:0] a);
    return (a == 2'd2) ? 2'd0 : a + 2'd1;
  endfunction

  // Padded to four bits so a 2-bit index is always in range.
  assign cyc_vec = {1'b0, i_ext_cyc, i_dbus_cyc, i_ibus_cyc};
  assign gcyc    = cyc_vec[grant];

  // Watchdog only fires while the owner still wants the bus and memory is silent;
  // a same-cycle ack takes precedence.
  assign wd_fire = (TIMEOUT != 0) && (state == BUSY) && gcyc && !i_mem_ack && (wdog == WD_LIMIT);
  assign ack_fwd = i_rst_n && (state == BUSY) && gcyc && (i_mem_ack || wd_fire);

  assign o_mem_cyc  = i_rst_n && (state == BUSY) && gcyc && !wd_fire;
  assign o_ibus_ack = ack_fwd && (grant == 2'd0);
  assign o_dbus_ack = ack_fwd && (grant == 2'd1);
  assign o_ext_ack  = ack_fwd && (grant == 2'd2);

  // A watchdog-terminated read returns zero to the owner instead of stale bus data.
  assign o_ibus_rdt = (wd_fire && grant == 2'd0) ? 32'd0 : i_mem_rdt;
  assign o_dbus_rdt = (wd_fire && grant == 2'd1) ? 32'd0 : i_mem_rdt;
  assign o_ext_rdt  = (wd_fire && grant == 2'd2) ? 32'd0 : i_mem_rdt;

  assign o_grant   = grant;
  assign o_busy    = (state == BUSY);
  assign o_timeout = timeout_q;

  always_comb begin
    o_mem_adr = i_ibus_adr;
    o_mem_dat = 32'd0;
    o_mem_sel = 4'hF;
    o_mem_we  = 1'b0;
    case (grant)
      2'd1: begin
        o_mem_adr = i_dbus_adr;
        o_mem_dat = i_dbus_dat;
        o_mem_sel = i_dbus_sel;
        o_mem_we  = i_dbus_we;
      end
      2'd2: begin
        o_mem_adr = i_ext_adr;
        o_mem_dat = i_ext_dat;
        o_mem_sel = i_ext_sel;
        o_mem_we  = i_ext_we;
      end
      default: ;
    endcase
  end

  // Round-robin search starting at the rotation pointer.
  always_comb begin
    win    = 2'd0;
    win_ok = 1'b0;
    cand   = ptr;
    for (int i = 0; i < 3; i++) begin
      if (!win_ok && cyc_vec[cand]) begin
        win    = cand;
        win_ok = 1'b1;
      end
      cand = inc3(cand);
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    ptr_nxt     = ptr;
    wdog_nxt    = wdog;
    timeout_nxt = timeout_q;
    case (state)
      IDLE: begin
        if (win_ok) begin
          state_nxt = BUSY;
          grant_nxt = win;
          wdog_nxt  = '0;
        end
      end
      BUSY: begin
        if (!gcyc || i_mem_ack || wd_fire) begin
          state_nxt = IDLE;
          ptr_nxt   = inc3(grant);
          if (wd_fire) timeout_nxt = 1'b1;
        end else if (wdog != WD_LIMIT) begin
          wdog_nxt = wdog + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      grant     <= 2'd0;
      ptr       <= 2'd0;
      wdog      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      ptr       <= ptr_nxt;
      wdog      <= wdog_nxt;
      timeout_q <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_servant_mem_sched.sv
// tb/tb_servant_mem_sched.sv - bench for servant_mem_sched
module tb_servant_mem_sched;

  localparam int AW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] adr [3];
  logic [31:0]   dat [3];
  logic [3:0]    sel [3];
  logic          we  [3];
  logic          cyc [3];
  logic [31:0]   mem_rdt;
  logic          mem_ack;

  logic [31:0]   ibus_rdt, dbus_rdt, ext_rdt;
  logic          ibus_ack, dbus_ack, ext_ack;
  logic [AW-1:0] mem_adr;
  logic [31:0]   mem_dat;
  logic [3:0]    mem_sel;
  logic          mem_we, mem_cyc;
  logic [1:0]    grant;
  logic          busy, tout;

  servant_mem_sched #(.AW(AW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ibus_adr(adr[0]), .i_ibus_cyc(cyc[0]), .o_ibus_rdt(ibus_rdt), .o_ibus_ack(ibus_ack),
    .i_dbus_adr(adr[1]), .i_dbus_dat(dat[1]), .i_dbus_sel(sel[1]), .i_dbus_we(we[1]),
    .i_dbus_cyc(cyc[1]), .o_dbus_rdt(dbus_rdt), .o_dbus_ack(dbus_ack),
    .i_ext_adr(adr[2]), .i_ext_dat(dat[2]), .i_ext_sel(sel[2]), .i_ext_we(we[2]),
    .i_ext_cyc(cyc[2]), .o_ext_rdt(ext_rdt), .o_ext_ack(ext_ack),
    .o_mem_adr(mem_adr), .o_mem_dat(mem_dat), .o_mem_sel(mem_sel), .o_mem_we(mem_we),
    .o_mem_cyc(mem_cyc), .i_mem_rdt(mem_rdt), .i_mem_ack(mem_ack),
    .o_grant(grant), .o_busy(busy), .o_timeout(tout)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit m_busy, m_to;
  int m_owner, m_ptr, m_cnt;
  bit ram_mode;

  // outputs sampled on the falling edge of the last cycle
  logic        s_ack [3];
  logic [31:0] s_rdt [3];
  logic        s_mem_cyc, s_busy, s_to, s_mem_we;
  logic [1:0]  s_grant;
  logic [3:0]  s_mem_sel;
  logic [31:0] s_mem_dat;
  logic [AW-1:0] s_mem_adr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: compare at the falling edge, advance the model across the rising edge.
  task automatic cycle();
    logic gcyc;
    bit   fire, found;
    bit   n_busy, n_to;
    int   n_owner, n_ptr, n_cnt, c;
    @(negedge clk);
    s_ack[0] = ibus_ack;  s_ack[1] = dbus_ack;  s_ack[2] = ext_ack;
    s_rdt[0] = ibus_rdt;  s_rdt[1] = dbus_rdt;  s_rdt[2] = ext_rdt;
    s_mem_cyc = mem_cyc;  s_busy = busy;  s_to = tout;  s_grant = grant;
    s_mem_we = mem_we;  s_mem_sel = mem_sel;  s_mem_dat = mem_dat;  s_mem_adr = mem_adr;

    gcyc = cyc[m_owner];
    fire = m_busy && gcyc && !mem_ack && (m_cnt >= TO);
    chk("busy", s_busy, m_busy);
    chk("mem_cyc", s_mem_cyc, rst_n && m_busy && gcyc && !fire);
    chk("timeout", s_to, m_to);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ack%0d", k), s_ack[k], rst_n && m_busy && gcyc && (mem_ack || fire) && (m_owner == k));
      chk($sformatf("rdt%0d", k), s_rdt[k], (fire && m_owner == k) ? 32'd0 : mem_rdt);
    end
    if (m_busy) begin
      chk("grant", s_grant, m_owner);
      chk("mem_adr", s_mem_adr, adr[m_owner]);
      chk("mem_we", s_mem_we, (m_owner == 0) ? 1'b0 : we[m_owner]);
      chk("mem_sel", s_mem_sel, (m_owner == 0) ? 4'hF : sel[m_owner]);
      chk("mem_dat", s_mem_dat, (m_owner == 0) ? 32'd0 : dat[m_owner]);
    end

    n_busy = m_busy; n_to = m_to; n_owner = m_owner; n_ptr = m_ptr; n_cnt = m_cnt;
    found = 0;
    if (!rst_n) begin
      n_busy = 0; n_to = 0; n_owner = 0; n_ptr = 0; n_cnt = 0;
    end else if (!m_busy) begin
      for (int i = 0; i < 3; i++) begin
        c = (m_ptr + i) % 3;
        if (!found && cyc[c]) begin
          found = 1;
          n_owner = c;
        end
      end
      if (found) begin
        n_busy = 1;
        n_cnt = 0;
      end
    end else if (!gcyc || mem_ack || fire) begin
      n_busy = 0;
      n_ptr = (m_owner + 1) % 3;
      if (fire) n_to = 1;
    end else begin
      n_cnt = m_cnt + 1;
    end

    @(posedge clk);
    #1;
    m_busy = n_busy; m_to = n_to; m_owner = n_owner; m_ptr = n_ptr; m_cnt = n_cnt;
    // servant_ram style: ack one cycle after cyc, never on two cycles in a row
    if (ram_mode) mem_ack = rst_n && s_mem_cyc && !mem_ack;
  endtask

  task automatic do_reset();
    rst_n = 0;
    for (int k = 0; k < 3; k++) cyc[k] = 0;
    mem_ack = 0;
    repeat (2) cycle();
    rst_n = 1;
  endtask

  int last, nack, busy_n, ack_at;

  initial begin
    rst_n = 0;
    mem_ack = 0;
    mem_rdt = 32'h0;
    ram_mode = 0;
    for (int k = 0; k < 3; k++) begin
      adr[k] = '0; dat[k] = '0; sel[k] = '0; we[k] = 0; cyc[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    m_busy = 0; m_to = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;

    // reset held with every master requesting
    for (int k = 0; k < 3; k++) cyc[k] = 1;
    repeat (3) begin
      cycle();
      chk("t1_memcyc", s_mem_cyc, 0);
      chk("t1_acks", {s_ack[0], s_ack[1], s_ack[2]}, 3'b000);
      chk("t1_busy", s_busy, 0);
      chk("t1_grant", s_grant, 0);
    end

    // single ibus read
    do_reset();
    ram_mode = 1;
    mem_rdt = 32'h1234_5678;
    adr[0] = 32'h100;
    cyc[0] = 1;
    cycle();
    chk("t2_cyc_t0", s_mem_cyc, 0);
    cycle();
    chk("t2_cyc_t1", s_mem_cyc, 1);
    chk("t2_adr_t1", s_mem_adr, 32'h100);
    chk("t2_ack_t1", s_ack[0], 0);
    cycle();
    chk("t2_ack_t2", s_ack[0], 1);
    chk("t2_rdt_t2", s_rdt[0], 32'h1234_5678);
    cyc[0] = 0;
    cycle();

    // all three continuously requesting
    do_reset();
    ram_mode = 1;
    for (int k = 0; k < 3; k++) begin
      cyc[k] = 1;
      adr[k] = 32'h1000 * (k + 1);
      dat[k] = 32'h11 * (k + 1);
      sel[k] = 4'h5;
      we[k]  = 0;
    end
    last = -1;
    nack = 0;
    for (int t = 0; t < 18; t++) begin
      cycle();
      for (int k = 0; k < 3; k++) begin
        if (s_ack[k]) begin
          chk("t3_order", k, nack % 3);
          if (last >= 0) chk("t3_gap", t - last, 3);
          last = t;
          nack++;
        end
      end
    end
    chk("t3_nacks", nack, 6);

    // dbus write
    do_reset();
    ram_mode = 1;
    adr[1] = 32'h40; dat[1] = 32'hDEAD_BEEF; sel[1] = 4'b0011; we[1] = 1; cyc[1] = 1;
    nack = 0;
    for (int t = 0; t < 6; t++) begin
      cycle();
      if (s_mem_cyc) begin
        chk("t4_we", s_mem_we, 1);
        chk("t4_sel", s_mem_sel, 4'b0011);
        chk("t4_dat", s_mem_dat, 32'hDEAD_BEEF);
      end
      if (s_ack[1]) begin
        nack++;
        cyc[1] = 0;
      end
    end
    chk("t4_nack", nack, 1);

    // watchdog on ext with memory silent
    do_reset();
    ram_mode = 0;
    mem_ack = 0;
    mem_rdt = 32'hA5A5_A5A5;
    adr[2] = 32'h80; we[2] = 0; sel[2] = 4'hF; cyc[2] = 1;
    busy_n = 0;
    ack_at = -1;
    for (int t = 0; t < 8; t++) begin
      cycle();
      if (s_busy) busy_n++;
      if (s_ack[2] && ack_at < 0) begin
        ack_at = busy_n;
        chk("t5_rdt", s_rdt[2], 0);
        cyc[2] = 0;
        cyc[0] = 1;
        adr[0] = 32'h200;
      end
    end
    chk("t5_ack_at", ack_at, 5);
    chk("t5_sticky", s_to, 1);
    chk("t5_busy", s_busy, 1);
    chk("t5_grant", s_grant, 0);

    // dbus abort, ext wins next
    do_reset();
    ram_mode = 0;
    mem_ack = 0;
    cyc[1] = 1;
    cyc[2] = 1;
    cycle();
    cycle();
    chk("t6_c1_cyc", s_mem_cyc, 1);
    chk("t6_c1_grant", s_grant, 1);
    cyc[1] = 0;
    cycle();
    chk("t6_c2_cyc", s_mem_cyc, 0);
    chk("t6_c2_ack", s_ack[1], 0);
    cycle();
    chk("t6_c3_busy", s_busy, 0);
    cycle();
    chk("t6_c4_busy", s_busy, 1);
    chk("t6_c4_grant", s_grant, 2);
    cyc[2] = 0;

    // randomized traffic, random memory latency, occasional reset
    do_reset();
    ram_mode = 0;
    for (int t = 0; t < 3000; t++) begin
      mem_ack = ($urandom_range(0, 2) == 0);
      mem_rdt = $urandom;
      rst_n = ($urandom_range(0, 299) != 0);
      for (int k = 0; k < 3; k++) begin
        if (!cyc[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            cyc[k] = 1;
            adr[k] = $urandom;
            dat[k] = $urandom;
            sel[k] = 4'($urandom_range(0, 15));
            we[k]  = 1'($urandom_range(0, 1));
          end
        end else if (s_ack[k]) begin
          cyc[k] = 0;
        end else if ($urandom_range(0, 24) == 0) begin
          cyc[k] = 0;
        end
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
